// File: rtl/sample_hex_framer_pkg.sv
// Shared types and constants for the sample-to-ASCII-hex framer.
// Holds the line state encoding and the nibble-to-character helper.
package sample_hex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IDX,
        COLON,
        HEX,
        LF,
        CR
    } state_e;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
    endfunction

endpackage

// File: rtl/sample_hex_framer_if.sv
// Sample input stream and ASCII byte output stream of the hex framer.
// The slave modport is the framer's view; master is the driving environment.
interface sample_hex_framer_if #(
    parameter int unsigned DATA_BITLEN = 24
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_BITLEN-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/sample_hex_framer_fifo.sv
// Single-clock first-word-fall-through FIFO holding raw samples.
// Push while full and pop while empty are ignored.
module sample_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sample_hex_framer.sv
// Buffers samples and emits each as an ASCII line: hex digits MSB-first, LF, CR.
// Define SAMPLE_HEX_FRAMER_INDEX_EN to prefix each line with a 4-digit index and ':'.
module sample_hex_framer
    import sample_hex_pkg::*;
#(
    parameter int unsigned DATA_BITLEN = 24,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    sample_hex_framer_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);

    localparam int unsigned NIBBLES  = DATA_BITLEN / 4;
    localparam int unsigned NW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES - 1);

`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
    localparam state_e LINE_START = IDX;
`else
    localparam state_e LINE_START = HEX;
`endif

    state_e                 state_q, state_d;
    logic [DATA_BITLEN-1:0] line_q, line_d;
    logic [NW-1:0]          nib_q, nib_d;
    logic                   out_valid_q, out_valid_d;
    logic [7:0]             out_data_q, out_data_d;
    logic                   run_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITLEN-1:0] fifo_head;

    logic                   slot_free;
    logic                   byte_vld;
    logic [7:0]             byte_data;

`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
    logic [15:0]            line_idx_q, line_idx_d;
    logic [1:0]             idx_nib_q, idx_nib_d;
    logic [15:0]            idx_shift;
`endif

    sample_fifo #(
        .WIDTH (DATA_BITLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (bus.in_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // run_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready  = run_q && !fifo_full;
    assign fifo_push     = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != IDLE) || (fifo_level != '0) || out_valid_q;

    // The FSM hands one byte per cycle to the output register whenever it is free.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        nib_d       = nib_q;
        fifo_pop    = 1'b0;
        byte_vld    = 1'b0;
        byte_data   = 8'h00;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        slot_free   = !out_valid_q || bus.out_ready;
`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
        line_idx_d  = line_idx_q;
        idx_nib_d   = idx_nib_q;
        idx_shift   = line_idx_q << {idx_nib_q, 2'b00};
`endif

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    line_d   = fifo_head;
                    nib_d    = '0;
                    state_d  = LINE_START;
                end
            end
`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
            IDX: begin
                byte_vld  = 1'b1;
                byte_data = nibble_to_ascii(idx_shift[15:12]);
                if (slot_free) begin
                    if (idx_nib_q == 2'd3) begin
                        idx_nib_d = 2'd0;
                        state_d   = COLON;
                    end else begin
                        idx_nib_d = idx_nib_q + 1'b1;
                    end
                end
            end
            COLON: begin
                byte_vld  = 1'b1;
                byte_data = ASCII_COLON;
                if (slot_free) begin
                    state_d = HEX;
                end
            end
`endif
            HEX: begin
                byte_vld  = 1'b1;
                byte_data = nibble_to_ascii(line_q[DATA_BITLEN-1 -: 4]);
                if (slot_free) begin
                    line_d = line_q << 4;
                    if (nib_q == LAST_NIB) begin
                        state_d = LF;
                    end else begin
                        nib_d = nib_q + 1'b1;
                    end
                end
            end
            LF: begin
                byte_vld  = 1'b1;
                byte_data = ASCII_LF;
                if (slot_free) begin
                    state_d = CR;
                end
            end
            CR: begin
                byte_vld  = 1'b1;
                byte_data = ASCII_CR;
                if (slot_free) begin
`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
                    line_idx_d = line_idx_q + 16'd1;
`endif
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        line_d   = fifo_head;
                        nib_d    = '0;
                        state_d  = LINE_START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (slot_free) begin
            out_valid_d = byte_vld;
            if (byte_vld) begin
                out_data_d = byte_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= '0;
            nib_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            nib_q       <= nib_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            run_q       <= 1'b1;
        end
    end

`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_idx_q <= 16'h0000;
            idx_nib_q  <= 2'd0;
        end else begin
            line_idx_q <= line_idx_d;
            idx_nib_q  <= idx_nib_d;
        end
    end
`endif

endmodule

// File: tb/tb_sample_hex_framer.sv
// Directed self-checking bench for sample_hex_framer (24-bit samples, 16-entry FIFO).
module tb_sample_hex_framer;

    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 16;
`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
    localparam int PFX = 5;
`else
    localparam int PFX = 0;
`endif
    localparam int LINE_LEN = DW / 4 + 2 + PFX;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] fifo_level;
    logic       busy;

    sample_hex_framer_if #(.DATA_BITLEN(DW)) bus ();

    sample_hex_framer #(
        .DATA_BITLEN (DW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         acc_cyc[$];
    int         rx_cyc[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [15:0] exp_idx = 16'h0000;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Output-side monitor: records transfers and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                checks++;
                assert (bus.out_valid === 1'b1 && bus.out_data === hold_data) else begin
                    errors++;
                    $error("FAIL hold observed valid=%b data=%h required valid=1 data=%h",
                           bus.out_valid, bus.out_data, hold_data);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                rx_q.push_back(bus.out_data);
                rx_cyc.push_back(cyc);
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                acc_cnt++;
                acc_cyc.push_back(cyc);
            end
            hold_pend = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            hold_data = bus.out_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic expect_line(input logic [DW-1:0] s);
`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
        for (int i = 3; i >= 0; i--) exp_q.push_back(hex_char(exp_idx[i*4 +: 4]));
        exp_q.push_back(8'h3A);
`endif
        for (int i = DW / 4 - 1; i >= 0; i--) exp_q.push_back(hex_char(s[i*4 +: 4]));
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
        exp_idx = exp_idx + 16'd1;
    endtask

    task automatic push_sample(input logic [DW-1:0] s, input bit add_exp);
        int k;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = s;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.in_ready !== 1'b1 && k < 300);
        if (bus.in_ready !== 1'b1) chk("push_timeout", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (add_exp) expect_line(s);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (rx_q.size() < n) chk("rx_timeout", 64'(rx_q.size()), 64'(n));
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk(tag, rx_q[i], exp_q[i]);
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
        acc_cyc.delete();
        exp_idx = 16'h0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hand [8];
        logic [DW-1:0] s;
        int k;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state while rst is held.
        #12;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, bus.out_data}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_fifo_level", {59'd0, fifo_level}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("rel_in_ready_before_edge", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1 chk("rel_in_ready_after_edge", {63'd0, bus.in_ready}, 64'd1);

        // 1: single sample, latency and byte order.
        bus.out_ready = 1'b1;
        acc_cyc.delete();
        push_sample(24'h0123AB, 1'b1);
        wait_rx(LINE_LEN, 50);
        hand = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h0A, 8'h0D};
        if (rx_q.size() >= LINE_LEN && acc_cyc.size() >= 1) begin
            chk("t1_latency", 64'(rx_cyc[0] - acc_cyc[0]), 64'd3);
            chk("t1_contig", 64'(rx_cyc[LINE_LEN-1] - rx_cyc[0]), 64'(LINE_LEN - 1));
            for (int i = 0; i < 8; i++) chk("t1_byte", rx_q[PFX+i], hand[i]);
        end
        compare_stream("t1_stream");

        // 2: back-to-back lines, no gap, busy drops after the final CR.
        push_sample(24'hFFFFFF, 1'b1);
        push_sample(24'h000000, 1'b1);
        wait_rx(2 * LINE_LEN, 80);
        chk("t2_busy_after", {63'd0, busy}, 64'd0);
        chk("t2_valid_after", {63'd0, bus.out_valid}, 64'd0);
        if (rx_q.size() >= 2 * LINE_LEN)
            chk("t2_contig", 64'(rx_cyc[2*LINE_LEN-1] - rx_cyc[0]), 64'(2 * LINE_LEN - 1));
        compare_stream("t2_stream");

        // 3: random samples against random backpressure.
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    s = DW'($urandom);
                    push_sample(s, 1'b1);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                k = 0;
                while (rx_q.size() < 64 * LINE_LEN && k < 4000) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                    k++;
                end
            end
        join
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_rx(64 * LINE_LEN, 200);
        compare_stream("t3_stream");

        // 4: fill under full backpressure; 16 in FIFO plus one in the line register.
        bus.out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        chk("t4_accepted", 64'(acc_cnt), 64'd17);
        chk("t4_level", {59'd0, fifo_level}, 64'd16);
        chk("t4_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("t4_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 17; i++) expect_line(DW'(i));
        bus.out_ready = 1'b1;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk("t4_ready_back", {63'd0, bus.in_ready}, 64'd1);
        chk("t4_level_after_pop", {59'd0, fifo_level}, 64'd15);
        wait_rx(17 * LINE_LEN, 400);
        compare_stream("t4_stream");

        // 5: asynchronous reset mid-line with samples queued.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push_sample(DW'(24'h111111 * i), 1'b0);
        bus.out_ready = 1'b1;
        wait_rx(3, 50);
        bus.out_ready = 1'b0;
        chk("t5_level_queued", {59'd0, fifo_level}, 64'd5);
        #1 rst = 1'b1;
        #1;
        chk("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_out_data", {56'd0, bus.out_data}, 64'd0);
        chk("t5_fifo_level", {59'd0, fifo_level}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_in_ready", {63'd0, bus.in_ready}, 64'd0);
        do_reset();
        chk("t5_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        push_sample(24'h00000A, 1'b1);
        wait_rx(LINE_LEN, 50);
        repeat (10) @(posedge clk);
        #1;
        if (rx_q.size() >= LINE_LEN) begin
            chk("t5_first_digit", rx_q[PFX], 8'h30);
            chk("t5_last_digit", rx_q[PFX+5], 8'h41);
        end
        compare_stream("t5_stream");

`ifdef SAMPLE_HEX_FRAMER_INDEX_EN
        // 6: line index prefix and its wrap.
        do_reset();
        push_sample(24'h000001, 1'b1);
        push_sample(24'h000001, 1'b1);
        wait_rx(2 * LINE_LEN, 80);
        if (rx_q.size() >= 2 * LINE_LEN) begin
            chk("t6_idx0_colon", rx_q[4], 8'h3A);
            chk("t6_idx1_digit", rx_q[LINE_LEN+3], 8'h31);
        end
        compare_stream("t6_stream");
        force dut.line_idx_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.line_idx_q;
        exp_idx = 16'hFFFF;
        push_sample(24'h000001, 1'b1);
        push_sample(24'h000001, 1'b1);
        wait_rx(2 * LINE_LEN, 80);
        if (rx_q.size() >= 2 * LINE_LEN) begin
            chk("t6_wrap_ffff", rx_q[0], 8'h46);
            chk("t6_wrap_0000", rx_q[LINE_LEN], 8'h30);
        end
        compare_stream("t6_wrap_stream");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
